// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for a req/gnt/rvalid port, backed by a word-addressed SRAM.
// Requests are granted combinationally. Responses return in order after RSP_LATENCY cycles.
// Out-of-range accesses get an error response.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_i / gnt_o     request valid / request accepted this cycle
//   we_i, be_i        write enable, byte enables
//   addr_i, wdata_i   byte address (bits [1:0] ignored), write data
//   rvalid_o          one response cycle per granted request
//   rdata_o, err_o    read data (0 for writes and errors), error flag
//
// Optional build macro: SRAM_RSP_RANDOM_STALL_EN. When it is defined, an 8-bit LFSR
// withholds the grant on about one cycle in four. This does not change response latency.
module sram_responder #(
  parameter int unsigned MEM_DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned RSP_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW      = $clog2(MEM_DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(4 * MEM_DEPTH_WORDS);
  localparam logic [2:0]  MAX_OUT = 3'(MAX_OUTSTANDING);

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          stall;
  logic          hs;
  logic [2:0]    out_cnt_q, out_cnt_d, out_eff;
  logic [31:0]   new_rdata;

  logic [31:0] mem [MEM_DEPTH_WORDS];

  logic [RSP_LATENCY-1:0] pipe_valid_q;
  logic [RSP_LATENCY-1:0] pipe_err_q;
  logic [31:0]            pipe_rdata_q [RSP_LATENCY];

  // Address decode. Unsigned wrap-around makes addresses below BASE_ADDR fall out of range.
  always_comb begin
    offset   = addr_i - BASE_ADDR;
    in_range = offset < SPAN;
    word_idx = offset[AW+1:2];
  end

`ifdef SRAM_RSP_RANDOM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    stall  = (lfsr_q[1:0] == 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // A response retiring this cycle frees its slot immediately. With MAX_OUTSTANDING below
  // RSP_LATENCY, this lets the grant reassert in the same cycle that rvalid is high.
  always_comb begin
    out_eff   = out_cnt_q - {2'b00, rvalid_o};
    gnt_o     = req_i && (out_eff < MAX_OUT) && !stall;
    hs        = req_i && gnt_o;
    out_cnt_d = out_cnt_q + {2'b00, hs} - {2'b00, rvalid_o};
    new_rdata = (hs && in_range && !we_i) ? mem[word_idx] : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= 3'd0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

  // SRAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (hs && in_range && we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) begin
          mem[word_idx][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Response shift register. Stage 0 captures the handshake and the last stage drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      for (int i = 0; i < RSP_LATENCY; i++) begin
        pipe_rdata_q[i] <= 32'h0;
      end
    end else begin
      pipe_valid_q[0] <= hs;
      pipe_err_q[0]   <= hs && !in_range;
      pipe_rdata_q[0] <= new_rdata;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_rdata_q[i] <= pipe_rdata_q[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid_q[RSP_LATENCY-1];
  assign err_o    = pipe_err_q[RSP_LATENCY-1];
  assign rdata_o  = pipe_rdata_q[RSP_LATENCY-1];

endmodule
